// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store; data-priority with fetch anti-starvation, watchdog abort.
// Latency: grant to ready pulse is 2+k cycles; requesters stall on req & ~ready and hold attributes until ready.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  mem_cmd_t      cmd, cmd_nxt;
  logic [3:0]    starve_cnt, starve_nxt;
  logic [7:0]    wd_cnt, wd_nxt;
  logic          mem_req_nxt;
  logic          if_ready_nxt, if_err_nxt, d_ready_nxt, d_err_nxt;
  logic [DW-1:0] if_rdata_nxt, d_rdata_nxt;
  logic          req_i, req_d, grant_d;
  logic          fin, fin_err;
  logic [DW-1:0] fin_dat;

  // A port is invisible to arbitration in its own ready cycle so a held req is not re-granted.
  assign req_i   = if_req & ~if_ready;
  assign req_d   = d_req & ~d_ready;
  assign grant_d = req_d & (~req_i | (starve_cnt < STARVE_LIM));

  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd;
    starve_nxt   = starve_cnt;
    wd_nxt       = wd_cnt;
    mem_req_nxt  = mem_req;
    if_ready_nxt = 1'b0;
    d_ready_nxt  = 1'b0;
    if_err_nxt   = if_err;
    d_err_nxt    = d_err;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_dat      = '0;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt   = BUSY_D;
          cmd_nxt     = '{we: d_we, addr: d_addr, wdata: d_wdata};
          mem_req_nxt = 1'b1;
          wd_nxt      = 8'd0;
          if (req_i) starve_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
          else       starve_nxt = 4'd0;
        end else if (req_i) begin
          state_nxt   = BUSY_I;
          cmd_nxt     = '{we: 1'b0, addr: if_addr, wdata: '0};
          mem_req_nxt = 1'b1;
          wd_nxt      = 8'd0;
          starve_nxt  = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        // mem_ready takes precedence over a watchdog expiring in the same cycle.
        if (mem_ready) begin
          fin     = 1'b1;
          fin_dat = cmd.we ? '0 : mem_rdata;
        end else begin
          wd_nxt = wd_cnt + 8'd1;
          if (wd_cnt == WD_LAST) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end
        if (fin) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          if (state == BUSY_D) begin
            d_ready_nxt = 1'b1;
            d_err_nxt   = fin_err;
            d_rdata_nxt = fin_dat;
          end else begin
            if_ready_nxt = 1'b1;
            if_err_nxt   = fin_err;
            if_rdata_nxt = fin_dat;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd        <= '0;
      starve_cnt <= 4'd0;
      wd_cnt     <= 8'd0;
      mem_req    <= 1'b0;
      if_ready   <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ready    <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      cmd        <= cmd_nxt;
      starve_cnt <= starve_nxt;
      wd_cnt     <= wd_nxt;
      mem_req    <= mem_req_nxt;
      if_ready   <= if_ready_nxt;
      if_err     <= if_err_nxt;
      if_rdata   <= if_rdata_nxt;
      d_ready    <= d_ready_nxt;
      d_err      <= d_err_nxt;
      d_rdata    <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, SMAX = 3, TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ready, if_err, d_req, d_we, d_ready, d_err;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ready;

  int            errors = 0, checks = 0;
  int            in_txn = 0, busy_n = 0, resp_k = 255;
  logic [DW-1:0] resp_data = '0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Advance one cycle and act as the memory: answer after resp_k busy cycles (255 = never).
  task automatic cycle();
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (in_txn != 0) busy_n++;
      else begin
        in_txn = 1;
        busy_n = 0;
      end
    end else in_txn = 0;
    mem_ready = mem_req && (busy_n == resp_k);
    mem_rdata = mem_ready ? resp_data : $urandom;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    cycle(); cycle();
    checks++; if ({if_ready, d_ready, if_err, d_err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {if_ready, d_ready, if_err, d_err}); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, d_rdata}); end
    checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_mem_ctl: got %b want 00", {mem_req, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL rst_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    reset = 1'b1;
    cycle(); cycle();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_idle: mem_req got %b want 0", mem_req); end
  endtask

  task automatic test_load_k0();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; resp_k = 0; resp_data = 32'hDEADBEEF;
    cycle();
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin errors++; $display("FAIL load_issue: got %b %h want 10 00000040", {mem_req, mem_we}, mem_addr); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL load_early_ready: got %b want 0", d_ready); end
    cycle();
    checks++; if ({d_ready, d_err, d_rdata} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL load_done: got %b %h want 10 deadbeef", {d_ready, d_err}, d_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load_mem_drop: got %b want 0", mem_req); end
    cycle();
    checks++; if ({mem_req, d_ready} !== 2'b00) begin errors++; $display("FAIL load_no_regrant: got %b want 00", {mem_req, d_ready}); end
    d_req = 1'b0;
    cycle();
  endtask

  task automatic test_store_k3();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; resp_k = 3; resp_data = 32'hFFFF0000;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++; if ({mem_req, mem_we, mem_wdata, d_ready} !== {2'b11, 32'h12345678, 1'b0}) begin
        errors++; $display("FAIL store_hold[%0d]: got %b %h %b want 11 12345678 0", i, {mem_req, mem_we}, mem_wdata, d_ready);
      end
    end
    cycle();
    checks++; if ({d_ready, d_err, d_rdata, mem_req} !== {2'b10, 32'h0, 1'b0}) begin errors++; $display("FAIL store_done: got %b %h %b want 10 0 0", {d_ready, d_err}, d_rdata, mem_req); end
    d_req = 1'b0; d_we = 1'b0;
    cycle();
  endtask

  // The completing port is masked in its ready cycle while the other port is still
  // requesting, so under continuous contention the grants alternate, one every 2 cycles.
  task automatic test_contention();
    int ng, last_c;
    logic prev_req;
    ng = 0; last_c = 0; prev_req = mem_req;
    if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    resp_k = 0; resp_data = 32'h0BADF00D;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      cycle();
      if (mem_req && !prev_req) begin
        checks++; if ((mem_addr == 32'h2000) !== (ng % 2 == 0)) begin errors++; $display("FAIL cont_order[%0d]: got addr %h want %s", ng, mem_addr, (ng % 2 == 0) ? "D" : "I"); end
        if (ng > 0) begin
          checks++; if (c - last_c != 2) begin errors++; $display("FAIL cont_spacing[%0d]: got %0d want 2", ng, c - last_c); end
        end
        last_c = c;
        ng++;
      end
      prev_req = mem_req;
    end
    checks++; if (ng != 6) begin errors++; $display("FAIL cont_grants: got %0d want 6", ng); end
    d_req = 1'b0;
    cycle();
    checks++; if ({if_ready, if_rdata} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL cont_last: got %b %h want 1 0badf00d", if_ready, if_rdata); end
    if_req = 1'b0;
    cycle();
  endtask

  task automatic test_timeout();
    if_req = 1'b1; if_addr = 32'h100; resp_k = 255;
    cycle();
    checks++; if ({mem_req, mem_we, mem_addr, if_ready} !== {2'b10, 32'h100, 1'b0}) begin errors++; $display("FAIL to_issue: got %b %h %b", {mem_req, mem_we}, mem_addr, if_ready); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int i = 2; i <= TO; i++) begin
      cycle();
      checks++; if ({mem_req, if_ready} !== 2'b10) begin errors++; $display("FAIL to_wait[%0d]: got %b want 10", i, {mem_req, if_ready}); end
    end
    resp_k = 0; resp_data = 32'h5555AAAA;
    cycle();
    checks++; if ({if_ready, if_err, if_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL to_abort: got %b %h want 11 0", {if_ready, if_err}, if_rdata); end
    checks++; if ({mem_req, d_ready} !== 2'b00) begin errors++; $display("FAIL to_drop: got %b want 00", {mem_req, d_ready}); end
    if_req = 1'b0;
    cycle();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL to_queued_d: got %b %h want 1 00000200", mem_req, mem_addr); end
    cycle();
    checks++; if ({d_ready, d_err, d_rdata} !== {2'b10, 32'h5555AAAA}) begin errors++; $display("FAIL to_queued_done: got %b %h", {d_ready, d_err}, d_rdata); end
    d_req = 1'b0;
    cycle();
  endtask

  task automatic test_race();
    if_req = 1'b1; if_addr = 32'h104; resp_k = TO - 1; resp_data = 32'hA5A50F0F;
    for (int i = 1; i <= TO; i++) begin
      cycle();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL race_busy[%0d]: got %b want 1", i, mem_req); end
    end
    cycle();
    checks++; if ({if_ready, if_err, if_rdata} !== {2'b10, 32'hA5A50F0F}) begin errors++; $display("FAIL race_done: got %b %h want 10 a5a50f0f", {if_ready, if_err}, if_rdata); end
    if_req = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; resp_k = 255;
    cycle(); cycle();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", mem_req); end
    reset = 1'b0; d_req = 1'b0;
    #1;
    checks++; if ({mem_req, mem_we, if_ready, d_ready, if_err, d_err} !== 6'b0) begin errors++; $display("FAIL rm_ctl_clear: got %b", {mem_req, mem_we, if_ready, d_ready, if_err, d_err}); end
    checks++; if ({if_rdata, d_rdata, mem_addr} !== 96'h0) begin errors++; $display("FAIL rm_data_clear: got %h", {if_rdata, d_rdata, mem_addr}); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if ({d_ready, mem_req} !== 2'b00) begin errors++; $display("FAIL rm_silent[%0d]: got %b want 00", i, {d_ready, mem_req}); end
    end
    reset = 1'b1;
    cycle();
    if_req = 1'b1; if_addr = 32'h400; resp_k = 1; resp_data = 32'h13579BDF;
    cycle();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h400}) begin errors++; $display("FAIL rm_fresh_issue: got %b %h", mem_req, mem_addr); end
    cycle();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rm_fresh_early: got %b want 0", if_ready); end
    cycle();
    checks++; if ({if_ready, if_err, if_rdata} !== {2'b10, 32'h13579BDF}) begin errors++; $display("FAIL rm_fresh_done: got %b %h", {if_ready, if_err}, if_rdata); end
    if_req = 1'b0;
    cycle();
  endtask

  // Fetch and data raised together, fetch withdrawn while data runs: after STARVE_MAX such
  // data wins the next simultaneous request goes to fetch.
  task automatic test_starve();
    resp_k = 0; resp_data = 32'h00C0FFEE;
    for (int ep = 0; ep < SMAX; ep++) begin
      if_req = 1'b1; if_addr = 32'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600 + 32'(ep * 4);
      cycle();
      checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h600 + 32'(ep * 4)}) begin errors++; $display("FAIL starve_d[%0d]: got %b %h", ep, mem_req, mem_addr); end
      if_req = 1'b0;
      cycle();
      d_req = 1'b0;
      cycle();
    end
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h700;
    cycle();
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h500}) begin errors++; $display("FAIL starve_i: got %b %h want 10 00000500", {mem_req, mem_we}, mem_addr); end
    cycle();
    if_req = 1'b0;
    cycle();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h700}) begin errors++; $display("FAIL starve_d_after: got %b %h", mem_req, mem_addr); end
    cycle();
    d_req = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    int n, g, k, hi, rc, starve, r;
    bit busy, go, t_d, t_we, pi, pd, ri, rd, act_i, act_d, exp_mreq, li_err, ld_err;
    logic [31:0] t_addr, t_wdata, t_data, li_rdata, ld_rdata;
    reset = 1'b0;
    idle_inputs();
    cycle(); cycle();
    reset = 1'b1;
    busy = 0; starve = 0; act_i = 0; act_d = 0; n = 0; g = 0; k = 0;
    t_d = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_data = '0;
    li_err = 0; ld_err = 0; li_rdata = '0; ld_rdata = '0;
    for (int c = 0; c < 1500; c++) begin
      cycle();
      n++;
      hi = (k < TO) ? k + 1 : TO;
      rc = g + 1 + hi;
      exp_mreq = busy && n > g && n <= g + hi;
      pi = busy && n == rc && !t_d;
      pd = busy && n == rc && t_d;
      if (busy && n == rc) begin
        if (t_d) begin ld_err = (k >= TO); ld_rdata = (k >= TO || t_we) ? 32'h0 : t_data; end
        else     begin li_err = (k >= TO); li_rdata = (k >= TO) ? 32'h0 : t_data; end
        busy = 0;
      end
      checks++; if (mem_req !== exp_mreq) begin errors++; $display("FAIL rnd_mem_req@%0d: got %b want %b", n, mem_req, exp_mreq); end
      if (exp_mreq) begin
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {t_we, t_addr, t_wdata}) begin
          errors++; $display("FAIL rnd_mem_cmd@%0d: got %b %h %h want %b %h %h", n, mem_we, mem_addr, mem_wdata, t_we, t_addr, t_wdata);
        end
      end
      checks++; if ({if_ready, d_ready} !== {pi, pd}) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", n, {if_ready, d_ready}, {pi, pd}); end
      checks++; if ({if_err, if_rdata} !== {li_err, li_rdata}) begin errors++; $display("FAIL rnd_if_resp@%0d: got %b %h want %b %h", n, if_err, if_rdata, li_err, li_rdata); end
      checks++; if ({d_err, d_rdata} !== {ld_err, ld_rdata}) begin errors++; $display("FAIL rnd_d_resp@%0d: got %b %h want %b %h", n, d_err, d_rdata, ld_err, ld_rdata); end
      // Requesters: hold until the ready pulse, optionally leave req high in that cycle.
      if (pi) begin act_i = 0; if ($urandom_range(1, 0) == 0) if_req = 1'b0; end
      else if (!act_i) begin
        if ($urandom_range(2, 0) == 0) begin act_i = 1; if_req = 1'b1; if_addr = $urandom; end
        else if_req = 1'b0;
      end
      if (pd) begin act_d = 0; if ($urandom_range(1, 0) == 0) d_req = 1'b0; end
      else if (!act_d) begin
        if ($urandom_range(2, 0) == 0) begin
          act_d = 1; d_req = 1'b1; d_we = 1'($urandom_range(1, 0)); d_addr = $urandom; d_wdata = $urandom;
        end else d_req = 1'b0;
      end
      if (!busy) begin
        go = 0;
        ri = if_req && !pi;
        rd = d_req && !pd;
        if (rd && (!ri || starve < SMAX)) begin
          t_d = 1; t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; go = 1;
          starve = ri ? ((starve < 15) ? starve + 1 : 15) : 0;
        end else if (ri) begin
          t_d = 0; t_we = 0; t_addr = if_addr; t_wdata = '0; go = 1; starve = 0;
        end
        if (go) begin
          busy = 1; g = n;
          r = $urandom_range(7, 0);
          k = (r < 4) ? r : (r == 4) ? TO - 1 : (r == 5) ? 255 : $urandom_range(2, 0);
          t_data = $urandom;
          resp_k = k; resp_data = t_data;
        end
      end
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_load_k0();
    test_store_k3();
    test_contention();
    test_timeout();
    test_race();
    test_reset_mid();
    test_starve();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
